vga_sync_receiver: RTL and testbench

Sink-side counterpart of the VGA timing generator: samples the hsync/vsync/blank/RGB stream, recovers the raster position of every sample, checks the stream against 640x480 timing (800x521 total), and emits active-video pixels with coordinates once locked. Used in loopback verification of the display path and as the front end of a frame-capture path. Tolerates a stalled source: only samples qualified by `pix_en` advance the raster.

---
 rtl/vga_sync_receiver.sv | 168 ++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// Sink side of the VGA timing path: recovers raster position, checks sync/blank timing, emits locked pixels.
// Optional VGA_RX_ERR_CNT_EN adds a saturating mismatch counter on err_count.
module vga_sync_receiver #(
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned V_TOTAL      = 521,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned H_SYNC_LEN   = 96,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_LEN   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic [23:0] pixel_out,
    output logic        pixel_valid,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic        locked,
    output logic        err_sticky,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_C   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FALL_C = 10'(H_SYNC_START);
    localparam logic [9:0] HS_RISE_C = 10'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [9:0] VS_FALL_C = 10'(V_SYNC_START);
    localparam logic [9:0] VS_RISE_C = 10'(V_SYNC_START + V_SYNC_LEN);

    state_t     state_r, state_s;
    logic [9:0] px_r, py_r;
    logic       prev_hs_r, prev_vs_r;
    logic [9:0] cur_px_s, cur_py_s, nxt_px_s, nxt_py_s;
    logic       hs_fall_s, hs_rise_s, vs_fall_s, vs_rise_s;
    logic       exp_blank_s, mismatch_s, err_s, accept_s;

    // Edge detection, predicted position of this sample and the timing checks.
    always_comb begin
        hs_fall_s = prev_hs_r & ~hsync;
        hs_rise_s = ~prev_hs_r & hsync;
        vs_fall_s = prev_vs_r & ~vsync;
        vs_rise_s = ~prev_vs_r & vsync;
        // A vsync fall while searching pins this sample to the start of the sync pulse.
        if (state_r == ST_SEARCH && vs_fall_s) begin
            cur_px_s = 10'd0;
            cur_py_s = VS_FALL_C;
        end else begin
            cur_px_s = px_r;
            cur_py_s = py_r;
        end
        if (cur_px_s == H_LAST_C) begin
            nxt_px_s = 10'd0;
            nxt_py_s = (cur_py_s == V_LAST_C) ? 10'd0 : cur_py_s + 10'd1;
        end else begin
            nxt_px_s = cur_px_s + 10'd1;
            nxt_py_s = cur_py_s;
        end
        exp_blank_s = (cur_px_s < H_ACT_C) && (cur_py_s < V_ACT_C);
        mismatch_s  = (hs_fall_s && cur_px_s != HS_FALL_C)
                    | (hs_rise_s && cur_px_s != HS_RISE_C)
                    | (vs_fall_s && (cur_px_s != 10'd0 || cur_py_s != VS_FALL_C))
                    | (vs_rise_s && (cur_px_s != 10'd0 || cur_py_s != VS_RISE_C))
                    | (blank != exp_blank_s);
        err_s    = pix_en && (state_r != ST_SEARCH) && mismatch_s;
        accept_s = pix_en && (state_r == ST_LOCKED) && blank && !mismatch_s;
    end

    // Lock state machine: next-state decision, only on qualified samples.
    always_comb begin
        state_s = state_r;
        if (pix_en) begin
            case (state_r)
                ST_SEARCH: state_s = vs_fall_s ? ST_ALIGN : ST_SEARCH;
                ST_ALIGN: begin
                    if (mismatch_s)     state_s = ST_SEARCH;
                    else if (vs_fall_s) state_s = ST_LOCKED;
                    else                state_s = ST_ALIGN;
                end
                ST_LOCKED: state_s = mismatch_s ? ST_SEARCH : ST_LOCKED;
                default:   state_s = ST_SEARCH;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, lock flag and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_SEARCH;
            locked     <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state_r    <= state_s;
            locked     <= (state_s == ST_LOCKED);
            err_sticky <= err_sticky | err_s;
        end
    end

    // Raster position and previous sync levels advance per qualified sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_r      <= 10'd0;
            py_r      <= 10'd0;
            prev_hs_r <= 1'b1;
            prev_vs_r <= 1'b1;
        end else if (pix_en) begin
            px_r      <= nxt_px_s;
            py_r      <= nxt_py_s;
            prev_hs_r <= hsync;
            prev_vs_r <= vsync;
        end
    end

    // Pixel output registers and one-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out   <= 24'd0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
        end else begin
            pixel_valid <= accept_s;
            frame_start <= accept_s && (cur_px_s == 10'd0) && (cur_py_s == 10'd0);
            if (accept_s) begin
                pixel_out <= {red, green, blue};
                x         <= cur_px_s;
                y         <= cur_py_s;
            end
        end
    end

`ifdef VGA_RX_ERR_CNT_EN
    logic [15:0] err_count_r;

    // Saturating count of mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= 16'h0000;
        end else if (err_s && err_count_r != 16'hFFFF) begin
            err_count_r <= err_count_r + 16'd1;
        end
    end

    assign err_count = err_count_r;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomized bench for vga_sync_receiver on a reduced raster, scored against a stream-level reference model.
module tb_vga_sync_receiver;

    localparam int H_T = 40;
    localparam int V_T = 16;
    localparam int HA  = 24;
    localparam int VA  = 10;
    localparam int HSS = 28;
    localparam int HSL = 6;
    localparam int VSS = 11;
    localparam int VSL = 2;
    localparam int FRAME = H_T * V_T;

    localparam int M_SEARCH = 0;
    localparam int M_ALIGN  = 1;
    localparam int M_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        blank = 1'b0;
    logic [7:0]  red = 8'd0, green = 8'd0, blue = 8'd0;
    logic [23:0] pixel_out;
    logic        pixel_valid;
    logic [9:0]  x, y;
    logic        frame_start, locked, err_sticky;
    logic [15:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int gx, gy;
    int m_phase = M_SEARCH;
    int m_errs = 0;
    bit m_sticky = 1'b0;
    int hs_fault_y = -1;
    int bl_fault_y = -1;
    int valid_cnt = 0;

    vga_sync_receiver #(
        .H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .blank(blank), .red(red), .green(green), .blue(blue),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid), .x(x), .y(y),
        .frame_start(frame_start), .locked(locked), .err_sticky(err_sticky),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at (%0d,%0d) t=%0t: got %0h expected %0h", tag, gx, gy, $time, got, exp);
        end
    endtask

    // One clock: present a sample (or idle noise), predict, then score the registered outputs.
    task automatic step(input bit en);
        bit          hs, vs, bl, act, fault, exp_valid, exp_fs;
        logic [23:0] rgb;
        logic [31:0] exp_cnt;
        int          ex, ey;
        exp_valid = 1'b0;
        exp_fs    = 1'b0;
        ex = 0;
        ey = 0;
        rgb = 24'd0;
        @(negedge clk);
        pix_en = en;
        if (en) begin
            act   = (gx < HA) && (gy < VA);
            hs    = !(gx >= HSS && gx < HSS + HSL);
            vs    = !(gy >= VSS && gy < VSS + VSL);
            bl    = act;
            fault = 1'b0;
            if (gy == hs_fault_y && gx == HSS) hs = 1'b1;
            if (gy == hs_fault_y && gx == HSS + 1) fault = 1'b1;
            if (gy == bl_fault_y && gx == HA) begin
                bl = 1'b1;
                fault = 1'b1;
            end
            rgb = act ? {8'(gy), 8'(gx), 8'hA5} : 24'($urandom);
            hsync = hs;
            vsync = vs;
            blank = bl;
            {red, green, blue} = rgb;
            if (m_phase == M_LOCKED && !fault && act) begin
                exp_valid = 1'b1;
                exp_fs    = (gx == 0 && gy == 0);
                ex = gx;
                ey = gy;
            end
            if (m_phase == M_SEARCH) begin
                if (gx == 0 && gy == VSS) m_phase = M_ALIGN;
            end else if (fault) begin
                m_phase  = M_SEARCH;
                m_errs   = m_errs + 1;
                m_sticky = 1'b1;
            end else if (gx == 0 && gy == VSS && m_phase == M_ALIGN) begin
                m_phase = M_LOCKED;
            end
            if (gx == H_T - 1) begin
                if (gy == hs_fault_y) hs_fault_y = -1;
                if (gy == bl_fault_y) bl_fault_y = -1;
                gx = 0;
                gy = (gy == V_T - 1) ? 0 : gy + 1;
            end else begin
                gx = gx + 1;
            end
        end else begin
            hsync = 1'($urandom);
            vsync = 1'($urandom);
            blank = 1'($urandom);
            {red, green, blue} = 24'($urandom);
        end
        if (!rst_n) begin
            m_phase   = M_SEARCH;
            m_errs    = 0;
            m_sticky  = 1'b0;
            exp_valid = 1'b0;
            exp_fs    = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("pixel_valid", 32'(pixel_valid), 32'(exp_valid));
        check_eq("frame_start", 32'(frame_start), 32'(exp_fs));
        if (exp_valid) begin
            check_eq("pixel_out", 32'(pixel_out), 32'(rgb));
            check_eq("x", 32'(x), 32'(ex));
            check_eq("y", 32'(y), 32'(ey));
        end
        if (!rst_n) begin
            check_eq("rst_pixel_out", 32'(pixel_out), 32'd0);
            check_eq("rst_xy", 32'({x, y}), 32'd0);
        end
        check_eq("locked", 32'(locked), 32'(m_phase == M_LOCKED));
        check_eq("err_sticky", 32'(err_sticky), 32'(m_sticky));
`ifdef VGA_RX_ERR_CNT_EN
        exp_cnt = (m_errs > 65535) ? 32'd65535 : 32'(m_errs);
`else
        exp_cnt = 32'd0;
`endif
        check_eq("err_count", 32'(err_count), exp_cnt);
        if (pixel_valid) valid_cnt++;
    endtask

    task automatic run_samples(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic goto_pos(input int tx, input int ty);
        for (int i = 0; i < FRAME && !(gx == tx && gy == ty); i++) step(1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_out"}, 32'(pixel_out), 32'd0);
        check_eq({tag, "_strobes"}, 32'({pixel_valid, frame_start}), 32'd0);
        check_eq({tag, "_xy"}, 32'({x, y}), 32'd0);
        check_eq({tag, "_flags"}, 32'({locked, err_sticky}), 32'd0);
        check_eq({tag, "_cnt"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        gx = $urandom_range(0, H_T - 1);
        gy = $urandom_range(0, VSS - 1);
        #1;
        check_all_zero("reset");
        step(1'b1);
        step(1'b1);
        rst_n = 1'b1;

        // Clean stream from an arbitrary raster position: lock within three frames.
        run_samples(3 * FRAME);
        check_eq("locked_after_clean", 32'(locked), 32'd1);

        goto_pos(0, 0);
        valid_cnt = 0;
        run_samples(FRAME);
        check_eq("frame_px_cont", 32'(valid_cnt), 32'(HA * VA));

        // Source stalling every other cycle; idle cycles carry noise.
        goto_pos(0, 0);
        valid_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1);
            step(1'b0);
        end
        check_eq("frame_px_toggle", 32'(valid_cnt), 32'(HA * VA));

        for (int i = 0; i < FRAME; i++) step(1'($urandom_range(0, 1)));

        // Late hsync fall on line 3, then relock.
        goto_pos(0, 0);
        hs_fault_y = 3;
        run_samples(3 * FRAME);
        check_eq("relock_after_hs", 32'(locked), 32'd1);

        // Blank asserted in the first horizontal blanking sample of line 5.
        goto_pos(0, 0);
        bl_fault_y = 5;
        run_samples(3 * FRAME);
        check_eq("relock_after_blank", 32'(locked), 32'd1);

        // Asynchronous reset mid-frame clears everything at once.
        goto_pos(20, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        step(1'b1);
        step(1'b1);
        rst_n = 1'b1;
        step(1'b1);
        check_eq("search_after_reset", 32'(locked), 32'd0);
        run_samples(3 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
